// File: rtl/disarm_cmd_sequencer.sv
// Disarm command front-end: qualifies one request at a time, pulses the executor,
// waits (bounded) for its done level and returns a status/result response.
module disarm_cmd_sequencer #(
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_force,
  output logic        req_ready,
  input  logic        landed,
  input  logic        throttle_low,
  output logic        start,
  input  logic        done,
  input  logic [31:0] result_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_REJECTED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);

  state_t            state, state_nx;
  logic              force_q, force_nx;
  logic [CNT_W-1:0]  hold_cnt, hold_nx, hold_inc;
  logic [CNT_W-1:0]  tmo_cnt, tmo_nx, tmo_inc;
  logic              rsp_valid_nx;
  logic [1:0]        status_nx;
  logic [31:0]       result_nx;

  assign req_ready = (state == S_IDLE);

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign hold_inc = (hold_cnt == '1) ? hold_cnt : hold_cnt + CNT_W'(1);
  assign tmo_inc  = (tmo_cnt  == '1) ? tmo_cnt  : tmo_cnt  + CNT_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx     = state;
    force_nx     = force_q;
    hold_nx      = hold_cnt;
    tmo_nx       = tmo_cnt;
    rsp_valid_nx = rsp_valid;
    status_nx    = rsp_status;
    result_nx    = rsp_result;

    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          force_nx = req_force;
          hold_nx  = '0;
          tmo_nx   = '0;
          state_nx = S_QUAL;
        end
      end

      S_QUAL: begin
        tmo_nx = tmo_inc;
        if (force_q) begin
          state_nx = S_ISSUE;
        end else begin
          hold_nx = (landed && throttle_low) ? hold_inc : '0;
          // Qualification is tested before the timeout so it wins a same-cycle tie.
          if (landed && throttle_low && (hold_inc >= HOLD_LIM)) begin
            state_nx = S_ISSUE;
          end else if (tmo_inc >= TMO_LIM) begin
            state_nx     = S_RESP;
            rsp_valid_nx = 1'b1;
            status_nx    = ST_REJECTED;
            result_nx    = '0;
          end
        end
      end

      S_ISSUE: begin
        tmo_nx   = '0;
        state_nx = S_WAIT;
      end

      S_WAIT: begin
        if (done) begin
          state_nx     = S_RESP;
          rsp_valid_nx = 1'b1;
          status_nx    = ST_OK;
          result_nx    = result_in;
        end else begin
          tmo_nx = tmo_inc;
          if (tmo_inc >= TMO_LIM) begin
            state_nx     = S_RESP;
            rsp_valid_nx = 1'b1;
            status_nx    = ST_TIMEOUT;
            result_nx    = '0;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state      <= S_IDLE;
      force_q    <= 1'b0;
      hold_cnt   <= '0;
      tmo_cnt    <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_result <= '0;
    end else begin
      state      <= state_nx;
      force_q    <= force_nx;
      hold_cnt   <= hold_nx;
      tmo_cnt    <= tmo_nx;
      // ISSUE lasts exactly one cycle, so registering its entry yields a single-cycle pulse.
      start      <= (state_nx == S_ISSUE);
      busy       <= (state_nx != S_IDLE);
      rsp_valid  <= rsp_valid_nx;
      rsp_status <= status_nx;
      rsp_result <= result_nx;
    end
  end

endmodule

// File: tb/tb_disarm_cmd_sequencer.sv
// Self-checking bench for disarm_cmd_sequencer: a scoreboard queue holds each expected
// response (status, result, first rsp_valid cycle) and a monitor compares on arrival.
module tb_disarm_cmd_sequencer;

  localparam int HOLD    = 8;
  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_force;
  logic        req_ready;
  logic        landed;
  logic        throttle_low;
  logic        start;
  logic        done;
  logic [31:0] result_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_result;
  logic        busy;

  typedef struct {
    logic [1:0]  status;
    logic [31:0] result;
    int          vcyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   rsp_seen = 1'b0;

  disarm_cmd_sequencer #(
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_force   (req_force),
    .req_ready   (req_ready),
    .landed      (landed),
    .throttle_low(throttle_low),
    .start       (start),
    .done        (done),
    .result_in   (result_in),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_status  (rsp_status),
    .rsp_result  (rsp_result),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] status, input logic [31:0] result, input int vcyc);
    exp_t e;
    e.status = status;
    e.result = result;
    e.vcyc   = vcyc;
    sb.push_back(e);
  endtask

  // Drives one request for the current cycle; returns the accept cycle k.
  task automatic accept(input logic frc, output int k);
    req_valid = 1'b1;
    req_force = frc;
    check("req_ready_idle", req_ready, 1'b1);
    k = cyc;
    step();
    req_valid = 1'b0;
    req_force = 1'b0;
  endtask

  // Returns in the cycle where start is seen high.
  task automatic wait_start(input int limit, output int sc);
    sc = -1;
    for (int i = 0; i < limit && sc < 0; i++) begin
      if (start) sc = cyc;
      else step();
    end
    check("start_seen", start, 1'b1);
  endtask

  // From a WAIT cycle: raise done for one cycle, then let the response drain to IDLE.
  task automatic finish_done(input logic [31:0] value);
    push_exp(2'b00, value, cyc + 1);
    done      = 1'b1;
    result_in = value;
    step();
    done      = 1'b0;
    result_in = '0;
    step();
    check("idle_after_rsp", busy, 1'b0);
  endtask

  // Scoreboard monitor: compares on the first rsp_valid cycle, pops on the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && !rsp_seen) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          check("rsp_cycle", cyc, sb[0].vcyc);
          check("rsp_status", rsp_status, sb[0].status);
          check("rsp_result", rsp_result, sb[0].result);
        end
        rsp_seen = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        rsp_seen = 1'b0;
      end
    end else begin
      rsp_seen = 1'b0;
    end
  end

  initial begin
    int k, sc, h, n_start;
    rst_n = 1'b0; req_valid = 1'b0; req_force = 1'b0; landed = 1'b0;
    throttle_low = 1'b0; done = 1'b0; result_in = '0; rsp_ready = 1'b1;
    step();
    step();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_status", rsp_status, 2'b00);
    check("rst_rsp_result", rsp_result, 32'h0);
    rst_n = 1'b1;
    step();

    // Forced request: start only in k+2, done in k+5 gives rsp_valid in k+6.
    accept(1'b1, k);
    check("frc_start_k1", start, 1'b0);
    check("frc_busy", busy, 1'b1);
    check("frc_req_ready_busy", req_ready, 1'b0);
    step();
    check("frc_start_k2", start, 1'b1);
    step();
    check("frc_start_k3", start, 1'b0);
    step();
    step();
    finish_done(32'hA5A5_0001);
    check("frc_rsp_k", k + 6, sb.size() == 0 ? k + 6 : -1);

    // Continuous qualification: start exactly HOLD+1 cycles after accept.
    landed = 1'b1; throttle_low = 1'b1;
    accept(1'b0, k);
    wait_start(40, sc);
    check("qual_start_cyc", sc, k + HOLD + 1);
    step();
    check("qual_start_pulse", start, 1'b0);
    finish_done(32'h1234_5678);

    // One-cycle glitch at k+5 restarts the hold count: start moves to k+14.
    accept(1'b0, k);
    repeat (4) step();
    throttle_low = 1'b0;
    step();
    throttle_low = 1'b1;
    wait_start(40, sc);
    check("glitch_start_cyc", sc, k + 14);
    step();
    finish_done(32'h0BAD_F00D);

    // Never landed: REJECTED response at k+TIMEOUT+1 and start never rises.
    landed = 1'b0;
    accept(1'b0, k);
    push_exp(2'b01, 32'h0, k + TIMEOUT + 1);
    n_start = 0;
    repeat (TIMEOUT + 6) begin
      if (start) n_start++;
      step();
    end
    check("rej_no_start", n_start, 0);
    check("rej_drained", sb.size(), 0);
    check("rej_idle", req_ready, 1'b1);

    // Executor never finishes: TIMEOUT WAIT cycles follow the start cycle, then status 10.
    accept(1'b1, k);
    wait_start(10, sc);
    push_exp(2'b10, 32'h0, sc + TIMEOUT + 1);
    repeat (TIMEOUT + 6) step();
    check("tmo_drained", sb.size(), 0);

    // done rising on the last WAIT cycle before timeout still reports OK.
    accept(1'b1, k);
    wait_start(10, sc);
    repeat (TIMEOUT) step();
    finish_done(32'hC0DE_0042);

    // Backpressure with a second request held during RESP.
    rsp_ready = 1'b0;
    accept(1'b1, k);
    wait_start(10, sc);
    step();
    push_exp(2'b00, 32'hDEAD_BEEF, cyc + 1);
    done = 1'b1; result_in = 32'hDEAD_BEEF;
    step();
    done = 1'b0; result_in = '0;
    req_valid = 1'b1; req_force = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_status", rsp_status, 2'b00);
      check("bp_rsp_result", rsp_result, 32'hDEAD_BEEF);
      check("bp_req_ready", req_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    h = cyc;
    step();
    check("b2b_rsp_dropped", rsp_valid, 1'b0);
    check("b2b_req_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0; req_force = 1'b0;
    check("b2b_accepted", busy, 1'b1);
    wait_start(10, sc);
    check("b2b_start_cyc", sc, h + 3);
    step();
    finish_done(32'h0000_0002);

    // Reset while in WAIT: back to IDLE at once and no response ever appears.
    accept(1'b1, k);
    wait_start(10, sc);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_req_ready", req_ready, 1'b1);
    n_start = 0;
    repeat (TIMEOUT + 10) begin
      if (start || rsp_valid) n_start++;
      step();
    end
    check("abort_quiet", n_start, 0);
    check("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
